md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//   Sequences the multiply/divide resource that feeds the E-stage extended ALU path.
//   Accepts a one-cycle start with operands and models fixed mult/div latency via busy.
//   Owns the architectural HI/LO registers.
//   Supports rollback of an operation squashed by an interrupt taken while it sits in M.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk       in   1   single clock, rising edge
//   reset     in   1   asynchronous, active-low; clears all state
//   start     in   1   op valid this cycle (pipeline already gated by IntReq)
//   op        in   3   operation code, see package
//   a         in   32  rs operand
//   b         in   32  rt operand
//   rollback  in   1   squash the op started in the previous cycle
//   busy      out  1   mult/div in progress; pipeline stalls dependent instructions
//   hi        out  32  architectural HI
//   lo        out  32  architectural LO
// BEHAVIOUR
//   - Reset (reset==0, any time): state=IDLE, busy=0, hi=0, lo=0, counter=0, backups=0.
//     Reset mid-operation discards the pending result.
//   - States: IDLE, RUN. IDLE --start&(MULT|MULTU|DIV|DIVU)--> RUN, count=N-1.
//     RUN decrements each cycle. At count==0 the next edge commits pending HI/LO,
//     sets busy=0 and returns to IDLE.
//   - Timing: start sampled at edge T0. busy=1 from T0 through T0+N. hi/lo show the
//     result after edge T0+N. Total latency N+1 edges, N = MULT_CYCLES or DIV_CYCLES.
//   - Pending result is computed from a,b at T0 and held in pend_hi/pend_lo.
//     hi/lo keep old values while busy.
//   - MULT: signed 32x32->64, {hi,lo}=a*b. MULTU: unsigned.
//   - DIV: lo=quotient and hi=remainder, truncating toward zero; remainder takes the
//     sign of the dividend. DIVU: unsigned.
//   - Divide by zero (b==0): latency still DIV_CYCLES; hi/lo unchanged at commit.
//   - MTHI/MTLO: commit a to hi/lo at T0. No busy. State unchanged.
//   - Backup: at every accepted start, bak_hi/bak_lo <= current hi/lo.
//   - rollback (valid only the cycle after a start; ignored otherwise):
//     - If RUN: abort to IDLE, busy=0 next edge, hi/lo unchanged.
//     - If last op was MTHI/MTLO: hi/lo <= bak_hi/bak_lo.
//     - rollback together with a new start: rollback wins and the start is dropped.
//   - start while busy: ignored. Illegal per pipeline contract; the bench asserts it.
//   - op codes 0 and 7 with start: no effect.
// STRUCTURE
//   - Shared package md_pkg holds the op localparams:
//     MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6.
//   - md_pkg also holds the state encoding: ST_IDLE=0, ST_RUN=1.
//   - One sub-module, md_core: combinational 64-bit result from (op,a,b), including
//     the signed/unsigned and div-by-zero handling.
//   - md_sequencer keeps the FSM, counter, pending, backup and HI/LO registers.
// TESTING
//   - MULT a=FFFFFFFD b=5 at T0: busy=1 for edges T0..T0+5, then hi=FFFFFFFF,
//     lo=FFFFFFF1 and busy=0.
//   - DIV a=7 b=FFFFFFFE: after 11 edges lo=FFFFFFFD, hi=00000001.
//     DIVU a=7 b=2: lo=3, hi=1.
//   - MTHI a=1234 (hi was 0), then rollback next cycle: hi returns to 0.
//     MTLO without rollback: lo=a after one edge.
//   - MULT start, rollback the next cycle: busy=0 after that edge and hi/lo stay at
//     their pre-start values.
//   - DIVU by zero with hi=AA, lo=BB: busy for 10 cycles, then hi=AA, lo=BB.
//   - Reset low during RUN: busy=0, hi=lo=0 immediately (asynchronous).
//     After release a new MULT 3*4 gives lo=C.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM encoding, widths.
package md_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned DATA_W = 32;

   localparam logic [OP_W-1:0] MD_NONE  = OP_W'(0);
   localparam logic [OP_W-1:0] MD_MULT  = OP_W'(1);
   localparam logic [OP_W-1:0] MD_MULTU = OP_W'(2);
   localparam logic [OP_W-1:0] MD_DIV   = OP_W'(3);
   localparam logic [OP_W-1:0] MD_DIVU  = OP_W'(4);
   localparam logic [OP_W-1:0] MD_MTHI  = OP_W'(5);
   localparam logic [OP_W-1:0] MD_MTLO  = OP_W'(6);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath: {hi,lo} result and a write-enable that drops on divide by zero.
module md_core
   import md_pkg::*;
(
   input  logic [OP_W-1:0]     op,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic [2*DATA_W-1:0] res,
   output logic                res_wr
);

   logic signed [DATA_W-1:0]   sa;
   logic signed [DATA_W-1:0]   sb;
   logic        [2*DATA_W-1:0] sx_a;
   logic        [2*DATA_W-1:0] sx_b;
   logic        [2*DATA_W-1:0] zx_a;
   logic        [2*DATA_W-1:0] zx_b;

   assign sa   = $signed(a);
   assign sb   = $signed(b);
   assign sx_a = {{DATA_W{a[DATA_W-1]}}, a};
   assign sx_b = {{DATA_W{b[DATA_W-1]}}, b};
   assign zx_a = {{DATA_W{1'b0}}, a};
   assign zx_b = {{DATA_W{1'b0}}, b};

   // Low 64 bits of a 64x64 product of extended operands give the exact 32x32 result.
   always_comb begin
      res    = '0;
      res_wr = 1'b0;
      case (op)
         MD_MULT: begin
            res    = sx_a * sx_b;
            res_wr = 1'b1;
         end
         MD_MULTU: begin
            res    = zx_a * zx_b;
            res_wr = 1'b1;
         end
         MD_DIV: begin
            if (b != '0) begin
               res    = {DATA_W'($unsigned(sa % sb)), DATA_W'($unsigned(sa / sb))};
               res_wr = 1'b1;
            end
         end
         MD_DIVU: begin
            if (b != '0) begin
               res    = {a % b, a / b};
               res_wr = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: fixed-latency busy model, HI/LO ownership, and one-cycle rollback.
module md_sequencer
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              rollback,
   output logic              busy,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                busy_d;
   logic [DATA_W-1:0]   hi_d, lo_d;
   logic [DATA_W-1:0]   pend_hi, pend_hi_d, pend_lo, pend_lo_d;
   logic                pend_wr, pend_wr_d;
   logic [DATA_W-1:0]   bak_hi, bak_hi_d, bak_lo, bak_lo_d;
   logic                last_start, last_start_d;
   logic                last_mt, last_mt_d;

   logic [2*DATA_W-1:0] core_res;
   logic                core_wr;
   logic                is_mul;
   logic                is_div;
   logic                is_mt;
   logic                do_rb;
   logic                accept;

   md_core u_core (
      .op     (op),
      .a      (a),
      .b      (b),
      .res    (core_res),
      .res_wr (core_wr)
   );

   assign is_mul = (op == MD_MULT) || (op == MD_MULTU);
   assign is_div = (op == MD_DIV)  || (op == MD_DIVU);
   assign is_mt  = (op == MD_MTHI) || (op == MD_MTLO);
   // Rollback only means something in the cycle right after an accepted start, and it beats any new start.
   assign do_rb  = rollback && last_start;
   assign accept = start && !do_rb && (state == ST_IDLE) && (is_mul || is_div || is_mt);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         busy       <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         pend_hi    <= '0;
         pend_lo    <= '0;
         pend_wr    <= 1'b0;
         bak_hi     <= '0;
         bak_lo     <= '0;
         last_start <= 1'b0;
         last_mt    <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         busy       <= busy_d;
         hi         <= hi_d;
         lo         <= lo_d;
         pend_hi    <= pend_hi_d;
         pend_lo    <= pend_lo_d;
         pend_wr    <= pend_wr_d;
         bak_hi     <= bak_hi_d;
         bak_lo     <= bak_lo_d;
         last_start <= last_start_d;
         last_mt    <= last_mt_d;
      end
   end

   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      busy_d       = busy;
      hi_d         = hi;
      lo_d         = lo;
      pend_hi_d    = pend_hi;
      pend_lo_d    = pend_lo;
      pend_wr_d    = pend_wr;
      bak_hi_d     = bak_hi;
      bak_lo_d     = bak_lo;
      last_start_d = 1'b0;
      last_mt_d    = last_mt;

      case (state)
         ST_IDLE: begin
            if (do_rb && last_mt) begin
               hi_d = bak_hi;
               lo_d = bak_lo;
            end
            if (accept) begin
               bak_hi_d     = hi;
               bak_lo_d     = lo;
               last_start_d = 1'b1;
               last_mt_d    = is_mt;
               if (is_mt) begin
                  if (op == MD_MTHI) hi_d = a;
                  else               lo_d = a;
               end else begin
                  state_d   = ST_RUN;
                  busy_d    = 1'b1;
                  cnt_d     = is_mul ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                  pend_hi_d = core_res[2*DATA_W-1:DATA_W];
                  pend_lo_d = core_res[DATA_W-1:0];
                  pend_wr_d = core_wr;
               end
            end
         end
         ST_RUN: begin
            if (do_rb) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else if (cnt == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               if (pend_wr) begin
                  hi_d = pend_hi;
                  lo_d = pend_lo;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer with hand-computed HI/LO and busy expectations.
module tb_md_sequencer;
   import md_pkg::*;

   localparam int unsigned MULT_N = 5;
   localparam int unsigned DIV_N  = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rollback;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int errors;

   md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .rollback (rollback),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The pipeline never issues a start while the unit is busy.
   always @(posedge clk) begin
      if (reset && start && busy && !rollback)
         assert (0) else $error("FAIL start_while_busy at %0t", $time);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a one-cycle start; returns 1ns after the edge that sampled it (T0).
   task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = xa;
      b     = xb;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = MD_NONE;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      start    = 1'b0;
      op       = MD_NONE;
      a        = '0;
      b        = '0;
      rollback = 1'b0;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Signed multiply: -3 * 5 = -15
      issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
      check("mult_busy_t0", 32'(busy), 32'd1);
      check("mult_hi_held", hi, 32'h0);
      for (int i = 1; i < int'(MULT_N); i++) begin
         step();
         check("mult_busy_run", 32'(busy), 32'd1);
      end
      check("mult_lo_held", lo, 32'h0);
      step();
      check("mult_busy_done", 32'(busy), 32'd0);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);

      // Signed divide: 7 / -2 = -3 rem 1
      issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
      for (int i = 1; i < int'(DIV_N); i++) step();
      check("div_busy_last", 32'(busy), 32'd1);
      check("div_hi_held", hi, 32'hFFFF_FFFF);
      step();
      check("div_busy_done", 32'(busy), 32'd0);
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'h1);

      // Unsigned divide: 7 / 2 = 3 rem 1
      issue(MD_DIVU, 32'd7, 32'd2);
      for (int i = 0; i < int'(DIV_N); i++) step();
      check("divu_lo", lo, 32'h3);
      check("divu_hi", hi, 32'h1);

      // Unsigned multiply with high bits: FFFFFFFF * 2 = 1_FFFFFFFE
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      for (int i = 0; i < int'(MULT_N); i++) step();
      check("multu_hi", hi, 32'h1);
      check("multu_lo", lo, 32'hFFFF_FFFE);

      // Clear hi, then MTHI followed by rollback restores it
      issue(MD_MTHI, 32'h0, 32'h0);
      check("mthi0_hi", hi, 32'h0);
      check("mthi0_busy", 32'(busy), 32'd0);
      issue(MD_MTHI, 32'h1234, 32'h0);
      check("mthi_hi", hi, 32'h1234);
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      check("mthi_rb_hi", hi, 32'h0);
      check("mthi_rb_lo", lo, 32'hFFFF_FFFE);

      issue(MD_MTLO, 32'h55, 32'h0);
      check("mtlo_lo", lo, 32'h55);
      step();
      // Late rollback, two edges after the start, must be ignored
      rollback = 1'b1;
      step();
      rollback = 1'b0;
      check("late_rb_lo", lo, 32'h55);

      // MULT squashed the next cycle; a concurrent start is dropped
      issue(MD_MULT, 32'd6, 32'd7);
      rollback = 1'b1;
      start    = 1'b1;
      op       = MD_MTHI;
      a        = 32'h999;
      step();
      rollback = 1'b0;
      start    = 1'b0;
      op       = MD_NONE;
      check("mult_rb_busy", 32'(busy), 32'd0);
      check("mult_rb_hi", hi, 32'h0);
      for (int i = 0; i < int'(MULT_N); i++) step();
      check("mult_rb_lo", lo, 32'h55);
      check("mult_rb_hi_late", hi, 32'h0);

      // Divide by zero keeps HI/LO but still takes the full latency
      issue(MD_MTHI, 32'hAA, 32'h0);
      issue(MD_MTLO, 32'hBB, 32'h0);
      issue(MD_DIVU, 32'd5, 32'd0);
      for (int i = 1; i < int'(DIV_N); i++) step();
      check("dz_busy_last", 32'(busy), 32'd1);
      step();
      check("dz_busy_done", 32'(busy), 32'd0);
      check("dz_hi", hi, 32'hAA);
      check("dz_lo", lo, 32'hBB);

      // Op code 7 does nothing
      issue(3'd7, 32'h1, 32'h1);
      check("op7_busy", 32'(busy), 32'd0);
      check("op7_hi", hi, 32'hAA);

      // Asynchronous reset in the middle of a run
      issue(MD_MULT, 32'd3, 32'd4);
      step();
      step();
      #2;
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_hi", hi, 32'h0);
      check("arst_lo", lo, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      issue(MD_MULT, 32'd3, 32'd4);
      for (int i = 0; i < int'(MULT_N); i++) step();
      check("post_rst_lo", lo, 32'hC);
      check("post_rst_hi", hi, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
